// File: rtl/harmonica_sequencer.sv
// Melody sequencer: steps a programmable {swar, dur} table and drives the
// harmonica datapath play/swar_select inputs, with an articulation gap per note.
module harmonica_sequencer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4,
    parameter int unsigned DUR_W      = 4,
    parameter int unsigned BEAT_TICKS = 2000,
    parameter int unsigned GAP_TICKS  = 400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DUR_W+2:0] wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic             play,
    output logic [2:0]       swar_select,
    output logic             busy,
    output logic [AW-1:0]    note_idx,
    output logic             done
);
    localparam int unsigned NW = DUR_W + $clog2(BEAT_TICKS + 1);
    localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int unsigned CW = (NW > GW) ? NW : GW;
    localparam int unsigned EW = DUR_W + 3;

    typedef enum logic [1:0] {ST_IDLE, ST_NOTE, ST_GAP} state_t;

    state_t           r_state, w_state_nx;
    logic [EW-1:0]    r_table [DEPTH];
    logic [2:0]       r_swar, w_swar_nx;
    logic [DUR_W-1:0] r_dur, w_dur_nx;
    logic [AW-1:0]    r_idx, w_idx_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic [CW-1:0]    w_cnt_inc, w_note_ticks;
    logic             r_play, r_busy, r_done, w_done_nx;
    logic             w_advance, w_load;
    logic [AW-1:0]    w_load_idx, w_next_idx;
    logic             w_ent0_ok, w_next_ok;

    assign w_note_ticks = CW'(r_dur) * CW'(BEAT_TICKS);
    assign w_cnt_inc    = r_cnt + CW'(1);
    assign w_next_idx   = r_idx + AW'(1);
    assign w_ent0_ok    = |r_table[0][DUR_W-1:0];
    assign w_next_ok    = (r_idx != AW'(DEPTH - 1)) && (|r_table[w_next_idx][DUR_W-1:0]);

    always_comb begin
        w_state_nx = r_state;
        w_swar_nx  = r_swar;
        w_dur_nx   = r_dur;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_done_nx  = 1'b0;
        w_advance  = 1'b0;
        w_load     = 1'b0;
        w_load_idx = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (w_ent0_ok) w_load    = 1'b1;
                    else           w_done_nx = 1'b1;
                end
            end
            ST_NOTE: begin
                if (stop) begin
                    w_state_nx = ST_IDLE;
                end else if (tick) begin
                    if (w_cnt_inc == w_note_ticks) begin
                        if (GAP_TICKS == 0) begin
                            w_advance = 1'b1;
                        end else begin
                            w_state_nx = ST_GAP;
                            w_cnt_nx   = '0;
                        end
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    w_state_nx = ST_IDLE;
                end else if (tick) begin
                    if (w_cnt_inc == CW'(GAP_TICKS)) w_advance = 1'b1;
                    else                             w_cnt_nx  = w_cnt_inc;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // Advance and loop restart share the fetch path below; w_load_idx stays 0 for restarts.
        if (w_advance) begin
            if (w_next_ok) begin
                w_load     = 1'b1;
                w_load_idx = w_next_idx;
            end else if (loop && w_ent0_ok) begin
                w_load = 1'b1;
            end else begin
                w_state_nx = ST_IDLE;
                w_done_nx  = 1'b1;
            end
        end

        if (w_load) begin
            w_state_nx = ST_NOTE;
            w_swar_nx  = r_table[w_load_idx][EW-1:DUR_W];
            w_dur_nx   = r_table[w_load_idx][DUR_W-1:0];
            w_idx_nx   = w_load_idx;
            w_cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_swar  <= '0;
            r_dur   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_play  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else begin
            r_state <= w_state_nx;
            r_swar  <= w_swar_nx;
            r_dur   <= w_dur_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_play  <= (w_state_nx == ST_NOTE);
            r_busy  <= (w_state_nx != ST_IDLE);
            r_done  <= w_done_nx;
            if (wr_en) r_table[wr_addr] <= wr_data;
        end
    end

    assign play        = r_play;
    assign swar_select = r_swar;
    assign busy        = r_busy;
    assign note_idx    = r_idx;
    assign done        = r_done;
endmodule
